// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types and sizing for the FU writeback arbiter slice.
// fu_output_t is the FU result bundle consumed from every functional unit.
package fu_wb_arbiter_pkg;

  localparam int NB_FU     = 4;
  localparam int NB_WB     = 2;
  localparam int BUF_DEPTH = 4;
  localparam int AF_MARGIN = 2;

  localparam int FU_IW = (NB_FU > 1) ? $clog2(NB_FU) : 1;
  localparam int WB_IW = (NB_WB > 1) ? $clog2(NB_WB) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  id;
    logic [5:0]  prd;
    logic [31:0] rdval;
  } fu_output_t;

  typedef struct packed {
    fu_output_t res;
    logic       valid;
  } wb_port_t;

endpackage

// File: rtl/fu_wb_fifo.sv
// Per-FU result FIFO; pointers carry one wrap bit so full and empty
// are distinguishable without a separate counter.
module fu_wb_fifo
  import fu_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fu_output_t               din_i,
  output fu_output_t               head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  fu_output_t mem_q [DEPTH];
  ptr_t       wr_q, wr_d;
  ptr_t       rd_q, rd_d;

  assign wr_d = push_i ? wr_q + ptr_t'(1) : wr_q;
  assign rd_d = pop_i  ? rd_q + ptr_t'(1) : rd_q;

  always_ff @(posedge clk) begin
    if (!rstn || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;

endmodule

// File: rtl/fu_wb_arbiter.sv
// Buffers FU results per unit and drains them round-robin onto the
// registered writeback ports feeding the PRF and ROB.
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  fu_output_t [NB_FU-1:0] fu_out_i,
  input  logic [NB_FU-1:0]       fu_out_valid_i,
  output logic [NB_FU-1:0]       fu_af_o,
  output fu_output_t [NB_WB-1:0] wb_o,
  output logic [NB_WB-1:0]       wb_valid_o,
  output logic                   overflow_o,
  input  logic                   squash
);

  fu_output_t [NB_FU-1:0] head;
  logic [NB_FU-1:0]       empty;
  logic [NB_FU-1:0]       full;
  logic [NB_FU-1:0]       push;
  logic [NB_FU-1:0]       pop;
  logic [CNT_W-1:0]       count [NB_FU];

  logic [FU_IW-1:0]       rr_q, rr_d;
  wb_port_t [NB_WB-1:0]   wb_q, wb_d;
  logic [NB_FU-1:0]       af_q, af_d;
  logic                   ovf_q, ovf_d;

  for (genvar i = 0; i < NB_FU; i++) begin : g_fifo
    fu_wb_fifo #(
      .DEPTH(BUF_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .flush_i (squash),
      .din_i   (fu_out_i[i]),
      .head_o  (head[i]),
      .empty_o (empty[i]),
      .full_o  (full[i]),
      .count_o (count[i])
    );
  end

  always_comb begin
    int               n;
    logic [FU_IW-1:0] idx;
    pop   = '0;
    push  = '0;
    wb_d  = '0;
    rr_d  = rr_q;
    ovf_d = 1'b0;
    af_d  = '0;
    n     = 0;
    idx   = '0;
    // squash freezes the scan so rr_ptr is held and nothing pops
    if (!squash) begin
      for (int s = 0; s < NB_FU; s++) begin
        idx = FU_IW'((int'(rr_q) + s) % NB_FU);
        if (!empty[idx] && n < NB_WB) begin
          pop[idx]                = 1'b1;
          wb_d[WB_IW'(n)].res     = head[idx];
          wb_d[WB_IW'(n)].valid   = 1'b1;
          rr_d = FU_IW'((int'(idx) + 1) % NB_FU);
          n    = n + 1;
        end
      end
    end
    for (int i = 0; i < NB_FU; i++) begin
      push[i] = fu_out_valid_i[i] && !squash &&
                (!full[i] || pop[i]);
      ovf_d   = ovf_d | (fu_out_valid_i[i] && !squash &&
                full[i] && !pop[i]);
      af_d[i] = count[i] >= CNT_W'(BUF_DEPTH - AF_MARGIN);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_q  <= '0;
      wb_q  <= '0;
      af_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      wb_q  <= wb_d;
      af_q  <= af_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NB_WB; k++) begin
      wb_o[k]       = wb_q[k].res;
      wb_valid_o[k] = wb_q[k].valid;
    end
  end

  assign fu_af_o    = af_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench for fu_wb_arbiter with a queue-based reference model
// checked every cycle plus hand-computed literal expectations.
module tb_fu_wb_arbiter;
  import fu_wb_arbiter_pkg::*;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   squash;
  fu_output_t [NB_FU-1:0] fu_out;
  logic [NB_FU-1:0]       fu_v;
  logic [NB_FU-1:0]       af;
  fu_output_t [NB_WB-1:0] wb;
  logic [NB_WB-1:0]       wbv;
  logic                   ovf;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fu_wb_arbiter dut (
    .clk            (clk),
    .rstn           (rstn),
    .fu_out_i       (fu_out),
    .fu_out_valid_i (fu_v),
    .fu_af_o        (af),
    .wb_o           (wb),
    .wb_valid_o     (wbv),
    .overflow_o     (ovf),
    .squash         (squash)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: one queue per FU, round-robin scan by index.
  fu_output_t       mq [NB_FU][$];
  int               m_rr;
  fu_output_t       e_wb [NB_WB];
  logic [NB_WB-1:0] e_v;
  logic             e_ovf;
  logic [NB_FU-1:0] e_af;
  bit               m_ok = 1'b0;

  always @(posedge clk) begin
    int g;
    int last;
    int f;
    if (!rstn) begin
      for (int i = 0; i < NB_FU; i++) mq[i].delete();
      m_rr  = 0;
      e_v   = '0;
      e_ovf = 1'b0;
      e_af  = '0;
      m_ok  = 1'b1;
    end else begin
      for (int i = 0; i < NB_FU; i++)
        e_af[i] = (mq[i].size() >= BUF_DEPTH - AF_MARGIN);
      e_v   = '0;
      e_ovf = 1'b0;
      if (squash) begin
        for (int i = 0; i < NB_FU; i++) mq[i].delete();
      end else begin
        g    = 0;
        last = -1;
        for (int s = 0; s < NB_FU; s++) begin
          f = (m_rr + s) % NB_FU;
          if (mq[f].size() > 0 && g < NB_WB) begin
            e_wb[g] = mq[f].pop_front();
            e_v[g]  = 1'b1;
            g++;
            last = f;
          end
        end
        if (last >= 0) m_rr = (last + 1) % NB_FU;
        for (int i = 0; i < NB_FU; i++) begin
          if (fu_v[i]) begin
            if (mq[i].size() < BUF_DEPTH) mq[i].push_back(fu_out[i]);
            else e_ovf = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_wbv", 128'(wbv), 128'(e_v));
      chk("m_ovf", 128'(ovf), 128'(e_ovf));
      chk("m_af", 128'(af), 128'(e_af));
      for (int k = 0; k < NB_WB; k++)
        if (e_v[k]) chk($sformatf("m_wb%0d", k), 128'(wb[k]), 128'(e_wb[k]));
    end
  end

  bit   col_on = 1'b0;
  logic [7:0] fu1_ids [$];

  always @(negedge clk) begin
    if (col_on)
      for (int k = 0; k < NB_WB; k++)
        if (wbv[k] && wb[k].id[7:4] == 4'h1) fu1_ids.push_back(wb[k].id);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    fu_v   = '0;
    squash = 1'b0;
  endtask

  function automatic fu_output_t mk(input int fu, input int n);
    fu_output_t r;
    r.pc    = 32'h1000 + 32'(n * 4);
    r.id    = 8'(fu * 16 + n);
    r.prd   = 6'(fu + 1);
    r.rdval = 32'(fu * 1000 + n);
    return r;
  endfunction

  task automatic drive(input int fu, input fu_output_t r);
    fu_out[fu] = r;
    fu_v[fu]   = 1'b1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    fu_output_t r;
    rstn   = 1'b0;
    squash = 1'b0;
    fu_v   = '0;
    fu_out = '0;
    step();
    step();
    chk("rst_wbv", 128'(wbv), 128'(0));
    chk("rst_af", 128'(af), 128'(0));
    chk("rst_ovf", 128'(ovf), 128'(0));
    rstn = 1'b1;

    // reset mid-burst with three or more FIFOs loaded
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NB_FU; i++) drive(i, mk(i, c));
      step();
    end
    rstn = 1'b0;
    idle();
    step();
    chk("mid_rst_wbv", 128'(wbv), 128'(0));
    chk("mid_rst_af", 128'(af), 128'(0));
    rstn = 1'b1;
    step();
    step();
    chk("mid_rst_empty", 128'(wbv), 128'(0));

    // single result, two-cycle latency
    r = '{pc: 32'h100, id: 8'd7, prd: 6'd3, rdval: 32'hdead};
    drive(0, r);
    step();
    idle();
    chk("lat1_wbv", 128'(wbv), 128'(0));
    step();
    chk("lat2_wbv", 128'(wbv), 128'(2'b01));
    chk("lat2_id", 128'(wb[0].id), 128'(8'd7));
    chk("lat2_rdval", 128'(wb[0].rdval), 128'(32'hdead));
    step();
    chk("lat3_wbv", 128'(wbv), 128'(0));

    // all four FUs at once from rr_ptr = 0
    do_reset();
    for (int i = 0; i < NB_FU; i++) begin
      r    = mk(i, 0);
      r.id = 8'(i);
      drive(i, r);
    end
    step();
    idle();
    step();
    chk("all4_a_wbv", 128'(wbv), 128'(2'b11));
    chk("all4_a_id0", 128'(wb[0].id), 128'(8'd0));
    chk("all4_a_id1", 128'(wb[1].id), 128'(8'd1));
    step();
    chk("all4_b_wbv", 128'(wbv), 128'(2'b11));
    chk("all4_b_id0", 128'(wb[0].id), 128'(8'd2));
    chk("all4_b_id1", 128'(wb[1].id), 128'(8'd3));
    step();
    chk("all4_c_wbv", 128'(wbv), 128'(0));
    drive(3, mk(3, 5));
    drive(0, mk(0, 5));
    step();
    idle();
    step();
    chk("rr0_id0", 128'(wb[0].id), 128'(8'h05));
    chk("rr0_id1", 128'(wb[1].id), 128'(8'h35));
    step();

    // sustained load on all FUs until FIFOs fill and drop
    do_reset();
    col_on = 1'b1;
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < NB_FU; i++) drive(i, mk(i, c));
      step();
      if (c == 2) chk("af1_e2", 128'(af[1]), 128'(0));
      if (c == 3) chk("af1_e3", 128'(af[1]), 128'(1));
      if (c == 6) chk("ovf_e6", 128'(ovf), 128'(0));
      if (c == 7) chk("ovf_e7", 128'(ovf), 128'(1));
      if (c == 8) chk("ovf_e8", 128'(ovf), 128'(1));
    end
    // full FIFOs 0 and 1 see push and pop together
    idle();
    drive(0, mk(0, 9));
    drive(1, mk(1, 9));
    step();
    idle();
    chk("fullpp_ovf", 128'(ovf), 128'(0));
    chk("fullpp_af0", 128'(af[0]), 128'(1));
    repeat (20) step();
    col_on = 1'b0;
    chk("fu1_cnt", 128'(fu1_ids.size()), 128'(9));
    for (int j = 0; j < fu1_ids.size() && j < 9; j++)
      chk($sformatf("fu1_ord%0d", j), 128'(fu1_ids[j]),
          128'((j < 8) ? (8'h10 + 8'(j)) : 8'h19));

    // squash with six buffered results and two live inputs
    do_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NB_FU; i++) drive(i, mk(i, c));
      step();
    end
    idle();
    squash = 1'b1;
    drive(0, mk(0, 2));
    drive(1, mk(1, 2));
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("sq_wbv%0d", c), 128'(wbv), 128'(0));
      chk($sformatf("sq_ovf%0d", c), 128'(ovf), 128'(0));
      if (c < 2) step();
    end
    drive(0, mk(0, 6));
    drive(3, mk(3, 6));
    step();
    idle();
    chk("post_sq_lat1", 128'(wbv), 128'(0));
    step();
    chk("post_sq_wbv", 128'(wbv), 128'(2'b11));
    chk("post_sq_id0", 128'(wb[0].id), 128'(8'h36));
    chk("post_sq_id1", 128'(wb[1].id), 128'(8'h06));
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
